// File: rtl/game_pkg.sv
// Shared types and constants for the game flow sequencer.
// State encoding is fixed because the display mux decodes it directly.
package game_pkg;

    typedef enum logic [2:0] {
        COVER = 3'd0,
        COUNT = 3'd1,
        PLAY  = 3'd2,
        PAUSE = 3'd3,
        OVER  = 3'd4
    } game_state_e;

    // Extended-flag bit in [8], scan code in [7:0].
    localparam logic [8:0] KEY_A           = 9'h01C;
    localparam logic [8:0] KEY_D           = 9'h023;
    localparam logic [8:0] KEY_P           = 9'h04D;
    localparam logic [8:0] KEY_ENTER       = 9'h05A;
    localparam logic [8:0] KEY_RIGHT_ENTER = 9'h15A;

    localparam int SCORE_W_DEF = 14;

endpackage

// File: rtl/game_flow_ctrl_key_hold_tracker.sv
// Tracks held A/D keys and the most recently pressed one; decodes Enter/Pause make events.
// hold/pref outputs already include the current event so the top can register them with one cycle latency.
module key_hold_tracker
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [8:0] key_code,
    input  logic       key_make,
    output logic       hold_a,
    output logic       hold_d,
    output logic       pref,
    output logic       enter_evt,
    output logic       pause_evt
);

    logic hold_a_q, hold_a_d;
    logic hold_d_q, hold_d_d;
    logic pref_q, pref_d;

    // pref: 0 = A pressed last, 1 = D pressed last.
    always_comb begin
        hold_a_d = hold_a_q;
        hold_d_d = hold_d_q;
        pref_d   = pref_q;
        if (key_valid) begin
            if (key_code == KEY_A) begin
                hold_a_d = key_make;
                if (key_make) pref_d = 1'b0;
            end
            if (key_code == KEY_D) begin
                hold_d_d = key_make;
                if (key_make) pref_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_a_q <= 1'b0;
            hold_d_q <= 1'b0;
            pref_q   <= 1'b0;
        end else begin
            hold_a_q <= hold_a_d;
            hold_d_q <= hold_d_d;
            pref_q   <= pref_d;
        end
    end

    assign hold_a    = hold_a_d;
    assign hold_d    = hold_d_d;
    assign pref      = pref_d;
    assign enter_evt = key_valid & key_make & ((key_code == KEY_ENTER) | (key_code == KEY_RIGHT_ENTER));
    assign pause_evt = key_valid & key_make & (key_code == KEY_P);

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: COVER -> COUNT -> PLAY <-> PAUSE, PLAY -> OVER -> COVER.
// state | meaning: COVER title | COUNT countdown | PLAY running | PAUSE frozen | OVER game-over hold
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int COUNT_TICKS = 3,
    parameter int OVER_TICKS  = 5,
    parameter int SCORE_W     = SCORE_W_DEF,
    parameter int SCORE_MAX   = 9999
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_valid,
    input  logic [8:0]         key_code,
    input  logic               key_make,
    input  logic               slime_die,
    input  logic               tick,
    output logic [2:0]         state,
    output logic               rst_game,
    output logic               freeze,
    output logic               move_left,
    output logic               move_right,
    output logic [1:0]         count_val,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] best
);

    localparam int OVC_W = $clog2(OVER_TICKS + 1);

    game_state_e        state_q, state_d;
    logic [1:0]         count_q, count_d;
    logic [OVC_W-1:0]   over_cnt_q, over_cnt_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] best_q, best_d;
    logic               entry_q, entry_d;
    logic               rst_game_q, rst_game_d;
    logic               freeze_q, freeze_d;
    logic               move_left_q, move_left_d;
    logic               move_right_q, move_right_d;

    logic hold_a, hold_d, pref, enter_evt, pause_evt;

    key_hold_tracker u_keys (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_make  (key_make),
        .hold_a    (hold_a),
        .hold_d    (hold_d),
        .pref      (pref),
        .enter_evt (enter_evt),
        .pause_evt (pause_evt)
    );

    // entry_q marks the first cycle spent in a newly entered state.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        over_cnt_d = over_cnt_q;
        score_d    = score_q;
        best_d     = best_q;
        case (state_q)
            COVER: begin
                if (enter_evt) begin
                    state_d = COUNT;
                    count_d = 2'(COUNT_TICKS);
                    score_d = '0;
                end
            end
            COUNT: begin
                if (tick && !entry_q) begin
                    if (count_q <= 2'd1) begin
                        state_d = PLAY;
                        count_d = '0;
                    end else begin
                        count_d = count_q - 2'd1;
                    end
                end
            end
            PLAY: begin
                if (slime_die) begin
                    state_d    = OVER;
                    over_cnt_d = OVC_W'(OVER_TICKS);
                    if (score_q > best_q) best_d = score_q;
                end else if (pause_evt) begin
                    state_d = PAUSE;
                end else if (tick && (score_q < SCORE_W'(SCORE_MAX))) begin
                    score_d = score_q + SCORE_W'(1);
                end
            end
            PAUSE: begin
                if (pause_evt) state_d = PLAY;
            end
            OVER: begin
                if (!entry_q) begin
                    if (enter_evt) begin
                        state_d = COVER;
                    end else if (tick) begin
                        if (over_cnt_q <= OVC_W'(1)) begin
                            state_d    = COVER;
                            over_cnt_d = '0;
                        end else begin
                            over_cnt_d = over_cnt_q - OVC_W'(1);
                        end
                    end
                end
            end
            default: state_d = COVER;
        endcase

        entry_d      = (state_d != state_q);
        rst_game_d   = !((state_d == PLAY) || (state_d == PAUSE));
        freeze_d     = (state_d == PAUSE);
        move_left_d  = (state_d == PLAY) & hold_a & (~hold_d | ~pref);
        move_right_d = (state_d == PLAY) & hold_d & (~hold_a | pref);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= COVER;
            count_q      <= '0;
            over_cnt_q   <= '0;
            score_q      <= '0;
            best_q       <= '0;
            entry_q      <= 1'b0;
            rst_game_q   <= 1'b1;
            freeze_q     <= 1'b0;
            move_left_q  <= 1'b0;
            move_right_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            over_cnt_q   <= over_cnt_d;
            score_q      <= score_d;
            best_q       <= best_d;
            entry_q      <= entry_d;
            rst_game_q   <= rst_game_d;
            freeze_q     <= freeze_d;
            move_left_q  <= move_left_d;
            move_right_q <= move_right_d;
        end
    end

    assign state      = state_q;
    assign rst_game   = rst_game_q;
    assign freeze     = freeze_q;
    assign move_left  = move_left_q;
    assign move_right = move_right_q;
    assign count_val  = count_q;
    assign score      = score_q;
    assign best       = best_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: directed scenarios plus a randomized run against a behavioural model.
module tb_game_flow_ctrl;
    import game_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [8:0]  key_code;
    logic        key_make;
    logic        slime_die;
    logic        tick;
    logic [2:0]  state;
    logic        rst_game, freeze, move_left, move_right;
    logic [1:0]  count_val;
    logic [13:0] score, best;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: 0 cover, 1 count, 2 play, 3 pause, 4 over.
    int m_state, m_cnt, m_score, m_best, m_over_left, m_age;
    bit m_ha, m_hd, m_pref_d;

    always #5 clk = ~clk;

    game_flow_ctrl dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .key_make(key_make),
        .slime_die(slime_die), .tick(tick), .state(state), .rst_game(rst_game), .freeze(freeze),
        .move_left(move_left), .move_right(move_right), .count_val(count_val), .score(score), .best(best)
    );

    task automatic model_step();
        bit enter, pause;
        int nxt;
        if (rst) begin
            m_state = 0; m_cnt = 0; m_score = 0; m_best = 0; m_over_left = 0; m_age = 0;
            m_ha = 0; m_hd = 0; m_pref_d = 0;
            return;
        end
        enter = key_valid && key_make && (key_code == 9'h05A || key_code == 9'h15A);
        pause = key_valid && key_make && (key_code == 9'h04D);
        if (key_valid && key_code == 9'h01C) begin m_ha = key_make; if (key_make) m_pref_d = 0; end
        if (key_valid && key_code == 9'h023) begin m_hd = key_make; if (key_make) m_pref_d = 1; end
        nxt = m_state;
        if (m_state == 0) begin
            if (enter) begin nxt = 1; m_cnt = 3; m_score = 0; end
        end else if (m_state == 1) begin
            if (tick && m_age > 0) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) nxt = 2;
            end
        end else if (m_state == 2) begin
            if (slime_die) begin
                nxt = 4; m_over_left = 5;
                m_best = (m_score > m_best) ? m_score : m_best;
            end else if (pause) nxt = 3;
            else if (tick) m_score = (m_score + 1 > 9999) ? 9999 : m_score + 1;
        end else if (m_state == 3) begin
            if (pause) nxt = 2;
        end else begin
            if (m_age > 0 && enter) nxt = 0;
            else if (m_age > 0 && tick) begin
                m_over_left = m_over_left - 1;
                if (m_over_left == 0) nxt = 0;
            end
        end
        m_age = (nxt != m_state) ? 0 : ((m_age < 1000) ? m_age + 1 : m_age);
        m_state = nxt;
    endtask

    task automatic cycle(input bit kv, input logic [8:0] code, input bit mk, input bit die, input bit tk);
        key_valid = kv; key_code = code; key_make = mk; slime_die = die; tick = tk;
        @(posedge clk);
        model_step();
        #1;
        key_valid = 1'b0; key_make = 1'b0; slime_die = 1'b0; tick = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 9'h000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 9'h000, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic press(input logic [8:0] code, input bit mk);
        cycle(1'b1, code, mk, 1'b0, 1'b0);
    endtask

    // From COVER: Enter, let the entry cycle pass, then run out the countdown.
    task automatic start_play();
        press(KEY_ENTER, 1'b1);
        idle(1);
        ticks(3);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
        n_checks++; if (rst_game !== 1'b1) begin n_fail++; $display("FAIL reset_rst_game: got %0b want 1", rst_game); end
        n_checks++; if (freeze !== 1'b0) begin n_fail++; $display("FAIL reset_freeze: got %0b want 0", freeze); end
        n_checks++; if ({move_left, move_right} !== 2'b00) begin n_fail++; $display("FAIL reset_moves: got %b want 00", {move_left, move_right}); end
        n_checks++; if (count_val !== 2'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count_val); end
        n_checks++; if (score !== 14'd0 || best !== 14'd0) begin n_fail++; $display("FAIL reset_scores: got %0d/%0d want 0/0", score, best); end
    endtask

    task automatic test_countdown();
        press(KEY_RIGHT_ENTER, 1'b1);
        n_checks++; if (state !== 3'd1 || count_val !== 2'd3) begin n_fail++; $display("FAIL cd_enter: got state %0d cnt %0d want 1/3", state, count_val); end
        idle(1);
        ticks(1);
        n_checks++; if (count_val !== 2'd2) begin n_fail++; $display("FAIL cd_tick1: got %0d want 2", count_val); end
        press(KEY_P, 1'b1);
        ticks(1);
        n_checks++; if (count_val !== 2'd1 || state !== 3'd1) begin n_fail++; $display("FAIL cd_tick2: got cnt %0d state %0d want 1/1", count_val, state); end
        ticks(1);
        n_checks++; if (state !== 3'd2 || count_val !== 2'd0 || rst_game !== 1'b0) begin
            n_fail++; $display("FAIL cd_play: got state %0d cnt %0d rst_game %0b want 2/0/0", state, count_val, rst_game); end
    endtask

    task automatic test_die_over();
        ticks(7);
        n_checks++; if (score !== 14'd7) begin n_fail++; $display("FAIL die_score7: got %0d want 7", score); end
        cycle(1'b0, 9'h000, 1'b0, 1'b1, 1'b1);
        n_checks++; if (state !== 3'd4 || score !== 14'd7 || best !== 14'd7 || rst_game !== 1'b1) begin
            n_fail++; $display("FAIL die_over: got state %0d score %0d best %0d rst_game %0b want 4/7/7/1", state, score, best, rst_game); end
        idle(1);
        ticks(4);
        n_checks++; if (state !== 3'd4) begin n_fail++; $display("FAIL over_hold: got %0d want 4", state); end
        ticks(1);
        n_checks++; if (state !== 3'd0 || score !== 14'd7) begin n_fail++; $display("FAIL over_done: got state %0d score %0d want 0/7", state, score); end
    endtask

    task automatic test_moves();
        start_play();
        press(KEY_A, 1'b1);
        n_checks++; if ({move_left, move_right} !== 2'b10) begin n_fail++; $display("FAIL mv_a: got %b want 10", {move_left, move_right}); end
        press(KEY_D, 1'b1);
        n_checks++; if ({move_left, move_right} !== 2'b01) begin n_fail++; $display("FAIL mv_ad: got %b want 01", {move_left, move_right}); end
        press(KEY_D, 1'b0);
        n_checks++; if ({move_left, move_right} !== 2'b10) begin n_fail++; $display("FAIL mv_dbrk: got %b want 10", {move_left, move_right}); end
        press(KEY_A, 1'b0);
        n_checks++; if ({move_left, move_right} !== 2'b00) begin n_fail++; $display("FAIL mv_abrk: got %b want 00", {move_left, move_right}); end
        cycle(1'b0, 9'h000, 1'b0, 1'b1, 1'b0);
        idle(1);
        press(KEY_ENTER, 1'b1);
        n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL mv_to_cover: got %0d want 0", state); end
        press(KEY_A, 1'b1);
        press(KEY_D, 1'b1);
        n_checks++; if ({move_left, move_right} !== 2'b00) begin n_fail++; $display("FAIL mv_cover: got %b want 00", {move_left, move_right}); end
        start_play();
        n_checks++; if ({move_left, move_right} !== 2'b01) begin n_fail++; $display("FAIL mv_held_into_play: got %b want 01", {move_left, move_right}); end
        press(KEY_D, 1'b0);
        press(KEY_A, 1'b0);
        cycle(1'b0, 9'h000, 1'b0, 1'b1, 1'b0);
        idle(1);
        press(KEY_ENTER, 1'b1);
    endtask

    task automatic test_back_to_back();
        start_play();
        ticks(10);
        cycle(1'b0, 9'h000, 1'b0, 1'b1, 1'b0);
        n_checks++; if (best !== 14'd10) begin n_fail++; $display("FAIL b2b_best10: got %0d want 10", best); end
        idle(1);
        press(KEY_ENTER, 1'b1);
        n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL b2b_enter_over: got %0d want 0", state); end
        start_play();
        n_checks++; if (score !== 14'd0) begin n_fail++; $display("FAIL b2b_score_clr: got %0d want 0", score); end
        ticks(6);
        cycle(1'b0, 9'h000, 1'b0, 1'b1, 1'b0);
        n_checks++; if (score !== 14'd6 || best !== 14'd10) begin n_fail++; $display("FAIL b2b_keep_best: got %0d/%0d want 6/10", score, best); end
        idle(1);
        press(KEY_ENTER, 1'b1);
    endtask

    task automatic test_pause();
        start_play();
        ticks(4);
        press(KEY_P, 1'b1);
        n_checks++; if (state !== 3'd3 || freeze !== 1'b1) begin n_fail++; $display("FAIL pause_enter: got state %0d freeze %0b want 3/1", state, freeze); end
        for (int i = 0; i < 3; i++) cycle(1'b1, KEY_ENTER, 1'b1, 1'b1, 1'b1);
        n_checks++; if (state !== 3'd3 || score !== 14'd4) begin n_fail++; $display("FAIL pause_hold: got state %0d score %0d want 3/4", state, score); end
        press(KEY_P, 1'b1);
        n_checks++; if (state !== 3'd2 || freeze !== 1'b0) begin n_fail++; $display("FAIL pause_exit: got state %0d freeze %0b want 2/0", state, freeze); end
        cycle(1'b1, KEY_P, 1'b1, 1'b0, 1'b1);
        n_checks++; if (state !== 3'd3 || score !== 14'd4) begin n_fail++; $display("FAIL pause_tick_same: got state %0d score %0d want 3/4", state, score); end
        press(KEY_P, 1'b1);
        cycle(1'b1, KEY_P, 1'b1, 1'b1, 1'b1);
        n_checks++; if (state !== 3'd4 || score !== 14'd4) begin n_fail++; $display("FAIL die_prio: got state %0d score %0d want 4/4", state, score); end
        idle(1);
        press(KEY_ENTER, 1'b1);
    endtask

    task automatic test_saturation();
        start_play();
        ticks(9998);
        n_checks++; if (score !== 14'd9998) begin n_fail++; $display("FAIL sat_9998: got %0d want 9998", score); end
        ticks(3);
        n_checks++; if (score !== 14'd9999) begin n_fail++; $display("FAIL sat_9999: got %0d want 9999", score); end
        cycle(1'b0, 9'h000, 1'b0, 1'b1, 1'b0);
        n_checks++; if (best !== 14'd9999) begin n_fail++; $display("FAIL sat_best: got %0d want 9999", best); end
        idle(1);
        press(KEY_ENTER, 1'b1);
    endtask

    task automatic test_random();
        logic [8:0] codes [6];
        logic [8:0] code;
        bit kv, mk, die, tk, quiet;
        codes[0] = KEY_A; codes[1] = KEY_D; codes[2] = KEY_P;
        codes[3] = KEY_ENTER; codes[4] = KEY_RIGHT_ENTER; codes[5] = 9'h11C;
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            quiet = (m_age == 0) && (m_state == 1 || m_state == 4);
            kv   = !quiet && ($urandom_range(0, 3) == 0);
            code = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(0, 511)) : codes[$urandom_range(0, 5)];
            mk   = ($urandom_range(0, 2) != 0);
            die  = ($urandom_range(0, 40) == 0);
            tk   = !quiet && ($urandom_range(0, 2) == 0);
            rst  = ($urandom_range(0, 499) == 0);
            cycle(kv, code, mk, die, tk);
            rst = 1'b0;
            n_checks++; if (state !== 3'(m_state)) begin n_fail++; $display("FAIL rnd_state @%0d: got %0d want %0d", i, state, m_state); end
            n_checks++; if (count_val !== 2'(m_cnt)) begin n_fail++; $display("FAIL rnd_count @%0d: got %0d want %0d", i, count_val, m_cnt); end
            n_checks++; if (score !== 14'(m_score)) begin n_fail++; $display("FAIL rnd_score @%0d: got %0d want %0d", i, score, m_score); end
            n_checks++; if (best !== 14'(m_best)) begin n_fail++; $display("FAIL rnd_best @%0d: got %0d want %0d", i, best, m_best); end
            n_checks++; if (rst_game !== (m_state != 2 && m_state != 3)) begin n_fail++; $display("FAIL rnd_rst_game @%0d: got %0b", i, rst_game); end
            n_checks++; if (freeze !== (m_state == 3)) begin n_fail++; $display("FAIL rnd_freeze @%0d: got %0b", i, freeze); end
            n_checks++; if (move_left !== (m_state == 2 && m_ha && (!m_hd || !m_pref_d))) begin n_fail++; $display("FAIL rnd_move_left @%0d: got %0b", i, move_left); end
            n_checks++; if (move_right !== (m_state == 2 && m_hd && (!m_ha || m_pref_d))) begin n_fail++; $display("FAIL rnd_move_right @%0d: got %0b", i, move_right); end
        end
    endtask

    initial begin
        rst = 1'b1; key_valid = 1'b0; key_code = 9'h000; key_make = 1'b0; slime_die = 1'b0; tick = 1'b0;
        test_reset();
        test_countdown();
        test_die_over();
        test_moves();
        test_back_to_back();
        test_pause();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Top-level game sequencer. It replaces the ad-hoc COVER/GAME flag and the per-cycle key pulse logic with a five-state flow: COVER, COUNT, PLAY, PAUSE and OVER. It consumes decoded PS/2 key events, the slime death flag and a slow tick. It produces the world reset, the freeze and movement controls, the display select, and the score and best-score counters.

Parameters:
COUNT_TICKS, 3, number of ticks spent in countdown before play starts.
OVER_TICKS, 5, number of ticks the game-over screen is held before returning to cover.
SCORE_W, 14, width of the score counters.
SCORE_MAX, 9999, saturation value of the score.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous active-high reset.
key_valid  in  1  one-cycle pulse: a key event is present on key_code and key_make.
key_code  in  9  extended-flag plus scan code of the event.
key_make  in  1  1 = press, 0 = release; sampled only while key_valid is high.
slime_die  in  1  level, high while the slime is dead.
tick  in  1  one-cycle pulse at the game time base.
state  out  3  current state (encoding in package); drives the display mux.
rst_game  out  1  world reset for floor and slime logic.
freeze  out  1  world clock-enable gate; high stops motion.
move_left  out  1  level: move the slime left.
move_right  out  1  level: move the slime right.
count_val  out  2  remaining countdown ticks, for display.
score  out  SCORE_W  ticks survived in the current run.
best  out  SCORE_W  highest score since rst.

Behaviour:
Clock, reset and output timing:
- Single clock domain. All outputs are registered and change one cycle after the causing input.
- Reset values: state=COVER, rst_game=1, freeze=0, move_left=move_right=0, count_val=0, score=0, best=0, internal hold flags=0, tick counter=0.

Key events:
- An event is key_valid high for one cycle.
- Enter is 9'h05A or 9'h15A, make only.
- Pause is 9'h04D, make only.
- Left is 9'h01C: a make sets hold_a, a break clears it.
- Right is 9'h023: a make sets hold_d, a break clears it.
- The last key made among A and D is remembered as pref.

Movement outputs:
- move_left = PLAY & hold_a & (~hold_d | pref==A).
- move_right = PLAY & hold_d & (~hold_a | pref==D).
- Both are never high together. Both are 0 outside PLAY.
- Hold flags keep tracking in every state.

State transitions:
- COVER: Enter -> COUNT; count_val=COUNT_TICKS; score=0.
- COUNT:
  - Each tick decrements count_val.
  - A tick while count_val==1 -> PLAY with count_val=0.
  - Enter and Pause are ignored.
- PLAY:
  - Each tick increments score, saturating at SCORE_MAX.
  - slime_die -> OVER. slime_die has priority over Pause and tick in the same cycle; no score increment occurs on that cycle.
  - Pause -> PAUSE.
- PAUSE:
  - Pause -> PLAY.
  - tick, slime_die and Enter are ignored; score is held.
- OVER:
  - On the entry cycle: best = max(best, score).
  - Counts OVER_TICKS ticks, then -> COVER.
  - Enter -> COVER immediately, but only after the entry cycle.

Derived outputs:
- rst_game = 1 in COVER, COUNT and OVER; 0 in PLAY and PAUSE.
- freeze = 1 only in PAUSE.

Simultaneous events:
- key_valid together with tick: both are processed, with key priority for the state change. Example: Pause plus tick in PLAY goes to PAUSE with no increment.
- A tick on the COUNT entry cycle is not counted.

Other:
- score is never cleared except on entry to COUNT and by rst. best is cleared only by rst.
- rst asserted mid-run returns to the reset values on the next edge, regardless of state.
- Undefined state encodings recover to COVER.

Decomposition:
- Package game_pkg holds:
  - state enum: COVER=0, COUNT=1, PLAY=2, PAUSE=3, OVER=4;
  - key code constants: KEY_A, KEY_D, KEY_P, KEY_ENTER, KEY_RIGHT_ENTER;
  - SCORE_W default.
- One sub-module, key_hold_tracker: takes key_valid, key_code and key_make, and produces hold_a, hold_d, pref, enter_evt and pause_evt.
- FSM, counters and best-score logic stay in game_flow_ctrl.

Test Plan:
- rst high 2 cycles then low, Enter make -> state COVER->COUNT next cycle, count_val=3; 3 ticks -> count_val 2,1, then PLAY; rst_game falls the same cycle.
- PLAY, 7 ticks, slime_die high together with the 8th tick -> state OVER; score=7; best=7; rst_game=1; after 5 ticks state=COVER.
- PLAY, A make then D make -> move_right=1, move_left=0; D break -> move_left=1; A break -> both 0; same sequence in COVER -> both 0.
- PLAY score=4, P make -> PAUSE, freeze=1; 3 ticks plus slime_die -> score=4, state PAUSE; P make -> PLAY, freeze=0.
- Force score to 9998 in PLAY, 3 ticks -> score=9999 held.
- Run ending with score 10, then run ending with score 6 -> best stays 10; Enter in OVER one cycle after entry -> COVER immediately.
